// File: rtl/charge_session_timer.sv
// Charge-session timer: computes ticks-to-full by iterative subtraction, then counts down.
// Define CHARGE_RESUME_EN to keep ChargeLevel across sessions and aborts.
module charge_session_timer #(
  parameter int unsigned TARGET   = 100,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        CounterEnable,
  input  logic [3:0]  CounterInput,
  input  logic        Stop,
  output logic [11:0] PresentTime,
  output logic [6:0]  ChargeLevel,
  output logic        Charging,
  output logic        Done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_CHARGING,
    S_DONE
  } state_t;

  localparam logic [7:0]  TGT8     = 8'(TARGET);
  localparam logic [6:0]  TGT7     = 7'(TARGET);
  localparam logic [11:0] DIV_LAST = 12'(TICK_DIV - 1);

  state_t      state;
  logic [3:0]  rate;
  logic [7:0]  remaining;
  logic [7:0]  quot;
  logic [11:0] presc;

  logic [7:0]  start_rem;
  logic [7:0]  lvl_sum;
  logic [6:0]  lvl_next;
  logic        tick;
  logic        accept;

  always_comb begin
`ifdef CHARGE_RESUME_EN
    start_rem = TGT8 - {1'b0, ChargeLevel};
`else
    start_rem = TGT8;
`endif
    lvl_sum  = {1'b0, ChargeLevel} + {4'b0, rate};
    lvl_next = (lvl_sum > TGT8) ? TGT7 : lvl_sum[6:0];
    tick     = (presc == DIV_LAST);
    // X or Z on the enable must not start a session
    accept   = (CounterEnable == 1'b1) && (CounterInput != 4'd0);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= S_IDLE;
      rate        <= '0;
      remaining   <= '0;
      quot        <= '0;
      presc       <= '0;
      PresentTime <= '0;
      ChargeLevel <= '0;
      Charging    <= 1'b0;
      Done        <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            rate      <= CounterInput;
            remaining <= start_rem;
            quot      <= '0;
`ifndef CHARGE_RESUME_EN
            ChargeLevel <= '0;
`endif
            if (start_rem == 8'd0) begin
              state <= S_DONE;
              Done  <= 1'b1;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (Stop) begin
            state       <= S_IDLE;
            PresentTime <= '0;
          end else if (remaining > {4'b0, rate}) begin
            remaining <= remaining - {4'b0, rate};
            quot      <= quot + 8'd1;
          end else begin
            quot        <= quot + 8'd1;
            PresentTime <= {4'b0, quot + 8'd1};
            presc       <= '0;
            Charging    <= 1'b1;
            state       <= S_CHARGING;
          end
        end
        S_CHARGING: begin
          if (Stop) begin
            state       <= S_IDLE;
            PresentTime <= '0;
            Charging    <= 1'b0;
            presc       <= '0;
          end else if (tick) begin
            presc       <= '0;
            ChargeLevel <= lvl_next;
            PresentTime <= PresentTime - 12'd1;
            if (PresentTime == 12'd1) begin
              state    <= S_DONE;
              Charging <= 1'b0;
              Done     <= 1'b1;
            end
          end else begin
            presc <= presc + 12'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_charge_session_timer.sv
// Directed bench for charge_session_timer (TARGET=100, TICK_DIV=4).
// Honours CHARGE_RESUME_EN for the build-dependent expectations.
module tb_charge_session_timer;

  logic        Clock;
  logic        Resetn;
  logic        CounterEnable;
  logic [3:0]  CounterInput;
  logic        Stop;
  logic [11:0] PresentTime;
  logic [6:0]  ChargeLevel;
  logic        Charging;
  logic        Done;

  int nvec;
  int nerr;

  charge_session_timer #(
    .TARGET  (100),
    .TICK_DIV(4)
  ) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .CounterEnable(CounterEnable),
    .CounterInput (CounterInput),
    .Stop         (Stop),
    .PresentTime  (PresentTime),
    .ChargeLevel  (ChargeLevel),
    .Charging     (Charging),
    .Done         (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        en;
    logic [3:0]  rate;
    logic        stop;
    int          cyc;
    logic [11:0] pt;
    logic [6:0]  lvl;
    logic        chg;
    logic        dn;
  } vec_t;

  vec_t tbl [14];

  task automatic clk(input int n);
    repeat (n) @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic chk(input string nm, input logic [11:0] pt,
                     input logic [6:0] lvl, input logic chg,
                     input logic dn);
    nvec++;
    if (PresentTime !== pt || ChargeLevel !== lvl ||
        Charging !== chg || Done !== dn) begin
      nerr++;
      $display("FAIL %s: got pt=%0d lvl=%0d chg=%b done=%b want pt=%0d lvl=%0d chg=%b done=%b",
               nm, PresentTime, ChargeLevel, Charging, Done,
               pt, lvl, chg, dn);
    end
  endtask

  task automatic do_reset();
    Resetn        = 1'b0;
    CounterEnable = 1'b0;
    CounterInput  = 4'd0;
    Stop          = 1'b0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;

    tbl[0]  = '{1'b0,  4'd0, 1'b0, 1,  12'd0,  7'd0,   1'b0, 1'b0};
    tbl[1]  = '{1'b1,  4'd5, 1'b0, 1,  12'd0,  7'd0,   1'b0, 1'b0};
    tbl[2]  = '{1'b1,  4'd5, 1'b0, 19, 12'd0,  7'd0,   1'b0, 1'b0};
    tbl[3]  = '{1'b0,  4'd0, 1'b0, 1,  12'd20, 7'd0,   1'b1, 1'b0};
    tbl[4]  = '{1'b0,  4'd0, 1'b0, 3,  12'd20, 7'd0,   1'b1, 1'b0};
    tbl[5]  = '{1'b0,  4'd0, 1'b0, 1,  12'd19, 7'd5,   1'b1, 1'b0};
    tbl[6]  = '{1'b1,  4'd1, 1'b0, 4,  12'd18, 7'd10,  1'b1, 1'b0};
    tbl[7]  = '{1'b0,  4'd0, 1'b0, 68, 12'd1,  7'd95,  1'b1, 1'b0};
    tbl[8]  = '{1'b0,  4'd0, 1'b0, 3,  12'd1,  7'd95,  1'b1, 1'b0};
    tbl[9]  = '{1'b0,  4'd0, 1'b0, 1,  12'd0,  7'd100, 1'b0, 1'b1};
    tbl[10] = '{1'b0,  4'd0, 1'b0, 1,  12'd0,  7'd100, 1'b0, 1'b0};
    tbl[11] = '{1'b1,  4'd0, 1'b0, 3,  12'd0,  7'd100, 1'b0, 1'b0};
    tbl[12] = '{1'bx,  4'd5, 1'b0, 3,  12'd0,  7'd100, 1'b0, 1'b0};
    tbl[13] = '{1'b0,  4'd5, 1'b1, 2,  12'd0,  7'd100, 1'b0, 1'b0};

    do_reset();
    chk("reset", 12'd0, 7'd0, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      CounterEnable = tbl[i].en;
      CounterInput  = tbl[i].rate;
      Stop          = tbl[i].stop;
      clk(tbl[i].cyc);
      chk($sformatf("vec%0d", i), tbl[i].pt, tbl[i].lvl,
          tbl[i].chg, tbl[i].dn);
    end
    Stop = 1'b0;

    // rate 1: 100 CALC cycles, then 100 ticks
    do_reset();
    CounterEnable = 1'b1;
    CounterInput  = 4'd1;
    clk(1);
    CounterEnable = 1'b0;
    clk(99);
    chk("r1_calc", 12'd0, 7'd0, 1'b0, 1'b0);
    clk(1);
    chk("r1_load", 12'd100, 7'd0, 1'b1, 1'b0);
    for (int t = 1; t <= 100; t++) begin
      clk(4);
      chk($sformatf("r1_tick%0d", t), 12'(100 - t), 7'(t),
          (t < 100), (t == 100));
    end
    CounterEnable = 1'b1;
    CounterInput  = 4'd5;
    clk(1);
    chk("b2b_idle", 12'd0, 7'd100, 1'b0, 1'b0);
    clk(1);
`ifdef CHARGE_RESUME_EN
    chk("b2b_full", 12'd0, 7'd100, 1'b0, 1'b1);
`else
    chk("b2b_acc", 12'd0, 7'd0, 1'b0, 1'b0);
`endif
    CounterEnable = 1'b0;

    // abort at PresentTime=12 during a rate-5 session
    do_reset();
    CounterEnable = 1'b1;
    CounterInput  = 4'd5;
    clk(1);
    CounterEnable = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (PresentTime == 12'd12) break;
      clk(1);
    end
    if (PresentTime != 12'd12) begin
      nvec++;
      nerr++;
      $display("FAIL stop_wait: got pt=%0d want pt=12 within 200 cycles",
               PresentTime);
    end
    Stop = 1'b1;
    clk(1);
    chk("stop", 12'd0, 7'd40, 1'b0, 1'b0);
    Stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      clk(1);
      chk($sformatf("stop_idle%0d", k), 12'd0, 7'd40, 1'b0, 1'b0);
    end

    // abort during CALC
    CounterEnable = 1'b1;
    CounterInput  = 4'd5;
    clk(1);
    CounterEnable = 1'b0;
    clk(5);
    Stop = 1'b1;
    clk(1);
    Stop = 1'b0;
`ifdef CHARGE_RESUME_EN
    chk("stop_calc", 12'd0, 7'd40, 1'b0, 1'b0);
`else
    chk("stop_calc", 12'd0, 7'd0, 1'b0, 1'b0);
`endif
    clk(3);
`ifdef CHARGE_RESUME_EN
    chk("stop_calc_idle", 12'd0, 7'd40, 1'b0, 1'b0);
`else
    chk("stop_calc_idle", 12'd0, 7'd0, 1'b0, 1'b0);
`endif

    // reach level 97, abort, then start a rate-5 session
    do_reset();
    CounterEnable = 1'b1;
    CounterInput  = 4'd1;
    clk(1);
    CounterEnable = 1'b0;
    clk(100);
    clk(4 * 97);
    chk("lvl97", 12'd3, 7'd97, 1'b1, 1'b0);
    Stop = 1'b1;
    clk(1);
    Stop = 1'b0;
    chk("lvl97_stop", 12'd0, 7'd97, 1'b0, 1'b0);
    CounterEnable = 1'b1;
    CounterInput  = 4'd5;
    clk(1);
    CounterEnable = 1'b0;
`ifdef CHARGE_RESUME_EN
    chk("res_calc", 12'd0, 7'd97, 1'b0, 1'b0);
    clk(1);
    chk("res_load", 12'd1, 7'd97, 1'b1, 1'b0);
    clk(4);
    chk("res_sat", 12'd0, 7'd100, 1'b0, 1'b1);
`else
    chk("res_calc", 12'd0, 7'd0, 1'b0, 1'b0);
    clk(19);
    chk("res_calc19", 12'd0, 7'd0, 1'b0, 1'b0);
    clk(1);
    chk("res_load", 12'd20, 7'd0, 1'b1, 1'b0);
`endif

    // asynchronous reset mid-CHARGING
    do_reset();
    CounterEnable = 1'b1;
    CounterInput  = 4'd5;
    clk(1);
    CounterEnable = 1'b0;
    clk(30);
    chk("pre_arst", 12'd18, 7'd10, 1'b1, 1'b0);
    #2 Resetn = 1'b0;
    #1 chk("arst", 12'd0, 7'd0, 1'b0, 1'b0);
    #1 Resetn = 1'b1;
    clk(1);
    chk("post_arst", 12'd0, 7'd0, 1'b0, 1'b0);
    CounterEnable = 1'b1;
    clk(1);
    CounterEnable = 1'b0;
    clk(20);
    chk("post_arst_sess", 12'd20, 7'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
